// File: rtl/stack_pkg.sv
// Shared definitions for the stack sequencer and the shift-register stacks.
// Op codes on the request side, delta encodings and fill pattern on the stack side.
package stack_pkg;

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_PUSH    = 3'b001;
    localparam logic [2:0] OP_POP     = 3'b010;
    localparam logic [2:0] OP_REPLACE = 3'b011;
    localparam logic [2:0] OP_POPREPL = 3'b100;

    // delta bit0 = move, bit1 = direction (1 = pop)
    localparam logic [1:0] DELTA_NONE = 2'b00;
    localparam logic [1:0] DELTA_PUSH = 2'b01;
    localparam logic [1:0] DELTA_POP  = 2'b11;

    // Value the stack shifts into vacated tail cells.
    localparam logic [17:0] EMPTY_FILL = 18'h15555;

    typedef struct packed {
        logic       we;
        logic [1:0] delta;
    } stk_ctl_t;

    // Reserved codes fall through to a plain NOP.
    function automatic stk_ctl_t op_encode(input logic [2:0] op);
        stk_ctl_t c;
        c.we    = 1'b0;
        c.delta = DELTA_NONE;
        case (op)
            OP_PUSH:    begin c.we = 1'b1; c.delta = DELTA_PUSH; end
            OP_POP:     begin c.we = 1'b0; c.delta = DELTA_POP;  end
            OP_REPLACE: begin c.we = 1'b1; c.delta = DELTA_NONE; end
            OP_POPREPL: begin c.we = 1'b1; c.delta = DELTA_POP;  end
            default:    begin c.we = 1'b0; c.delta = DELTA_NONE; end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/stack_depth.sv
// Saturating stack occupancy counter with over/underflow detection.
// Depth updates on the accepting edge; error pulses are combinational in the accept cycle.
// No backpressure of its own: only counts when accept is asserted.
module stack_depth
    import stack_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = $clog2(DEPTH + 2)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          accept,
    input  logic [2:0]    op,
    output logic [DW-1:0] depth,
    output logic          ovf,
    output logic          unf
);

    localparam logic [DW-1:0] CAP = DW'(DEPTH + 1);

    logic [DW-1:0] depth_nxt;

    always_comb begin
        depth_nxt = depth;
        ovf       = 1'b0;
        unf       = 1'b0;
        if (accept) begin
            case (op)
                OP_PUSH: begin
                    if (depth == CAP) ovf = 1'b1;
                    else              depth_nxt = depth + DW'(1);
                end
                OP_POP: begin
                    if (depth == '0) unf = 1'b1;
                    else             depth_nxt = depth - DW'(1);
                end
                OP_REPLACE: begin
                    if (depth == '0) begin
                        unf = 1'b1;
`ifndef STACK_CTL_GUARD_EN
                        // The write invents a head cell out of nothing.
                        depth_nxt = DW'(1);
`endif
                    end
                end
                OP_POPREPL: begin
                    if (depth >= DW'(2)) depth_nxt = depth - DW'(1);
                    else begin
                        unf = 1'b1;
`ifndef STACK_CTL_GUARD_EN
                        depth_nxt = DW'(1);
`endif
                    end
                end
                default: depth_nxt = depth;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) depth <= '0;
        else        depth <= depth_nxt;
    end

endmodule

// File: rtl/stack_ctl.sv
// Stack op sequencer: registers ops into stack we/delta/wd, tracks depth, sticky errors (opt. STACK_CTL_GUARD_EN).
// Latency 1 cycle from acceptance to stack control outputs.
// req_ready = !hold; while hold is high every output register and depth is frozen.
module stack_ctl
    import stack_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16,
    parameter int DW    = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    output logic             stk_we,
    output logic [1:0]       stk_delta,
    output logic [WIDTH-1:0] stk_wd,
    output logic [DW-1:0]    depth,
    output logic             empty,
    output logic             full,
    output logic             err_ovf,
    output logic             err_unf,
    input  logic             err_clr
);

    localparam logic [DW-1:0] CAP = DW'(DEPTH + 1);

    logic     accept;
    logic     ovf_pulse;
    logic     unf_pulse;
    logic     issue;
    stk_ctl_t enc;

    assign req_ready = !hold;
    assign accept    = req_valid && !hold;
    assign enc       = op_encode(req_op);

`ifdef STACK_CTL_GUARD_EN
    // Faulting ops are flagged but reach the stack as NOP so its contents survive.
    assign issue = accept && !(ovf_pulse || unf_pulse);
`else
    assign issue = accept;
`endif

    stack_depth #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_depth (
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (accept),
        .op     (req_op),
        .depth  (depth),
        .ovf    (ovf_pulse),
        .unf    (unf_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stk_we    <= 1'b0;
            stk_delta <= DELTA_NONE;
            stk_wd    <= '0;
        end else if (!hold) begin
            if (issue) begin
                stk_we    <= enc.we;
                stk_delta <= enc.delta;
                if (enc.we) stk_wd <= req_data;
            end else begin
                stk_we    <= 1'b0;
                stk_delta <= DELTA_NONE;
            end
        end
    end

    // Set beats clear; clear works even while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            if (ovf_pulse)    err_ovf <= 1'b1;
            else if (err_clr) err_ovf <= 1'b0;
            if (unf_pulse)    err_unf <= 1'b1;
            else if (err_clr) err_unf <= 1'b0;
        end
    end

    assign empty = (depth == '0);
    assign full  = (depth == CAP);

endmodule

// File: tb/tb_stack_ctl.sv
// Scoreboard bench for stack_ctl: a reference model queues expected outputs per cycle.
// Inputs change on the falling edge; outputs are compared on the following falling edge.
module tb_stack_ctl;

    localparam int W   = 18;
    localparam int CAP = 17;
    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, REPL = 3'd3, POPREPL = 3'd4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hold = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_op = 3'd0;
    logic [W-1:0]  req_data = '0;
    logic          stk_we;
    logic [1:0]    stk_delta;
    logic [W-1:0]  stk_wd;
    logic [4:0]    depth;
    logic          empty, full, err_ovf, err_unf;
    logic          err_clr = 1'b0;

    stack_ctl dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data), .stk_we(stk_we), .stk_delta(stk_delta),
        .stk_wd(stk_wd), .depth(depth), .empty(empty), .full(full),
        .err_ovf(err_ovf), .err_unf(err_unf), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         we;
        logic [1:0]   delta;
        logic [W-1:0] wd;
        int           dep;
        logic         ovf;
        logic         unf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic         m_we, m_ovf, m_unf;
    logic [1:0]   m_delta;
    logic [W-1:0] m_wd;
    int           m_depth;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_we = 0; m_delta = 2'b00; m_wd = '0; m_depth = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic model_step(input bit v, input bit h, input bit c, input logic [2:0] o,
                              input logic [W-1:0] d);
        bit e_o = 0, e_u = 0, sup = 0;
        int nd = m_depth;
        if (!h && v) begin
            case (o)
                PUSH:    if (m_depth == CAP) e_o = 1; else nd = m_depth + 1;
                POP:     if (m_depth == 0) e_u = 1; else nd = m_depth - 1;
                REPL:    if (m_depth == 0) begin e_u = 1; nd = 1; end
                POPREPL: if (m_depth >= 2) nd = m_depth - 1; else begin e_u = 1; nd = 1; end
                default: ;
            endcase
`ifdef STACK_CTL_GUARD_EN
            if (e_o || e_u) begin nd = m_depth; sup = 1; end
`endif
            m_depth = nd;
            m_we = 0; m_delta = 2'b00;
            if (!sup) begin
                case (o)
                    PUSH:    begin m_we = 1; m_delta = 2'b01; m_wd = d; end
                    POP:     begin m_we = 0; m_delta = 2'b11; end
                    REPL:    begin m_we = 1; m_delta = 2'b00; m_wd = d; end
                    POPREPL: begin m_we = 1; m_delta = 2'b11; m_wd = d; end
                    default: ;
                endcase
            end
        end else if (!h) begin
            m_we = 0; m_delta = 2'b00;
        end
        if (e_o) m_ovf = 1; else if (c) m_ovf = 0;
        if (e_u) m_unf = 1; else if (c) m_unf = 0;
    endtask

    task automatic compare(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, ".we"},    32'(stk_we),    32'(e.we));
        chk({tag, ".delta"}, 32'(stk_delta), 32'(e.delta));
        chk({tag, ".wd"},    32'(stk_wd),    32'(e.wd));
        chk({tag, ".depth"}, 32'(depth),     32'(e.dep));
        chk({tag, ".empty"}, 32'(empty),     32'(e.dep == 0));
        chk({tag, ".full"},  32'(full),      32'(e.dep == CAP));
        chk({tag, ".ovf"},   32'(err_ovf),   32'(e.ovf));
        chk({tag, ".unf"},   32'(err_unf),   32'(e.unf));
    endtask

    // Called on a falling edge; spans exactly one rising edge.
    task automatic step(input string tag, input bit v, input bit h, input bit c,
                        input logic [2:0] o, input logic [W-1:0] d);
        req_valid = v; hold = h; err_clr = c; req_op = o; req_data = d;
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 32'(!h));
        model_step(v, h, c, o, d);
        sb.push_back('{m_we, m_delta, m_wd, m_depth, m_ovf, m_unf});
        @(negedge clk);
        compare(tag);
    endtask

    task automatic do_reset();
        rst_n = 0; req_valid = 0; hold = 0; err_clr = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();
        // reset values against constants
        chk("rst.we", 32'(stk_we), 0);
        chk("rst.delta", 32'(stk_delta), 0);
        chk("rst.wd", 32'(stk_wd), 0);
        chk("rst.depth", 32'(depth), 0);
        chk("rst.empty", 32'(empty), 1);
        chk("rst.full", 32'(full), 0);
        chk("rst.flags", 32'({err_ovf, err_unf}), 0);

        step("push11", 1, 0, 0, PUSH, 18'h00011);
        chk("push11.lit", 32'({stk_we, stk_delta, stk_wd}), 32'({1'b1, 2'b01, 18'h00011}));
        step("push22", 1, 0, 0, PUSH, 18'h00022);
        chk("push22.depth", 32'(depth), 2);
        step("pop", 1, 0, 0, POP, 18'h0);
        chk("pop.lit", 32'({stk_we, stk_delta, depth}), 32'({1'b0, 2'b11, 5'd1}));
        step("idle", 0, 0, 0, PUSH, 18'h3);
        step("rsvd", 1, 0, 0, 3'b101, 18'h2AAAA);

        // fill to capacity and beyond
        do_reset();
        for (int i = 0; i < 17; i++) step("fill", 1, 0, 0, PUSH, 18'(i + 1));
        chk("fill.full", 32'(full), 1);
        step("ovf", 1, 0, 0, PUSH, 18'h1234);
        chk("ovf.lit", 32'({err_ovf, depth}), 32'({1'b1, 5'd17}));
        step("ovfclr", 0, 0, 1, NOP, 18'h0);
        chk("ovfclr.lit", 32'(err_ovf), 0);

        // drain, then underflow; set beats a coincident clear
        for (int i = 0; i < 17; i++) step("drain", 1, 0, 0, POP, 18'h0);
        step("unf", 1, 0, 0, POP, 18'h0);
        chk("unf.flag", 32'(err_unf), 1);
        step("unfset", 1, 0, 1, POP, 18'h0);
        step("unfclr_hold", 0, 1, 1, NOP, 18'h0);
        chk("unfclr_hold.lit", 32'(err_unf), 0);
        step("repl0", 1, 0, 0, REPL, 18'h00555);
        step("unfclr", 0, 0, 1, NOP, 18'h0);

        // hold freezes everything for three cycles
        step("pre", 1, 0, 0, PUSH, 18'h00abc);
        for (int i = 0; i < 3; i++) step("hold", 1, 1, 0, PUSH, 18'h00def);
        step("release", 1, 0, 0, PUSH, 18'h00def);

        // POPREPL from depth 3 and at depth 1
        do_reset();
        for (int i = 0; i < 3; i++) step("p3", 1, 0, 0, PUSH, 18'(i + 16));
        step("poprepl", 1, 0, 0, POPREPL, 18'h3FFFF);
        chk("poprepl.lit", 32'({stk_we, stk_delta, stk_wd, depth}),
            32'({1'b1, 2'b11, 18'h3FFFF, 5'd2}));
        step("pop1", 1, 0, 0, POP, 18'h0);
        step("poprepl1", 1, 0, 0, POPREPL, 18'h00077);
        chk("poprepl1.lit", 32'({err_unf, depth}), 32'({1'b1, 5'd1}));

        // reset in the cycle after accepting a PUSH
        step("mid", 1, 0, 0, PUSH, 18'h00099);
        req_valid = 0;
        #1 rst_n = 0;
        #1;
        model_reset();
        chk("midrst.lit", 32'({stk_we, stk_delta, stk_wd, depth, err_ovf, err_unf}), 0);
        @(negedge clk);
        rst_n = 1;
        step("postrst", 0, 0, 0, NOP, 18'h0);
        chk("postrst.lit", 32'({stk_we, stk_delta, depth}), 0);

        // random traffic
        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 9) == 0), 3'($urandom_range(0, 7)), 18'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_ctl.md
Name: stack_ctl

Overview:
- Upstream sequencer for the shift-register data/return stacks.
- Accepts abstract stack operations over a valid/ready handshake and registers them into the stack's we/delta/wd controls.
- Tracks occupancy and raises sticky overflow/underflow flags, so the core and debugger can detect lost or invented stack cells.
- One instance per stack (data, return).

Parameters:
- WIDTH, 18, stack cell width in bits; must match the downstream stack.
- DEPTH, 16, tail depth of the downstream stack. Capacity CAP = DEPTH+1 (head plus tail).
- DW, $clog2(DEPTH+2), width of the depth counter; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  global stall, same signal as the stack's hold
- req_valid  in  1  operation request present
- req_ready  out  1  request accepted this cycle; equals !hold
- req_op  in  3  000 NOP, 001 PUSH, 010 POP, 011 REPLACE, 100 POPREPL; 101–111 reserved
- req_data  in  WIDTH  write data for PUSH/REPLACE/POPREPL
- stk_we  out  1  to stack we
- stk_delta  out  2  to stack delta: bit0 = move, bit1 = pop direction
- stk_wd  out  WIDTH  to stack wd
- depth  out  DW  valid cells, 0..CAP
- empty  out  1  depth==0
- full  out  1  depth==CAP
- err_ovf  out  1  sticky overflow
- err_unf  out  1  sticky underflow
- err_clr  in  1  clears both sticky flags

Behaviour:
- Reset (async, rst_n low): stk_we=0, stk_delta=00, stk_wd=0, depth=0, empty=1, full=0, err_ovf=0, err_unf=0. Reset mid-operation discards any registered op; no stack update is issued after release until a new request is accepted.
- Acceptance: a request is accepted on a rising edge with req_valid && !hold. req_ready is combinational !hold.
- Output register:
  - An accepted op is registered in the cycle it is accepted and presented on stk_* in the next cycle. The stack applies it at the end of that cycle.
  - Latency is 1 cycle from acceptance to stack update.
  - No accepted request (hold=0) registers a NOP: we=0, delta=00.
  - While hold=1, all stk_* outputs and depth hold their values.
- Op encodings to stack:
  - PUSH → we=1, delta=01, wd=req_data
  - POP → we=0, delta=11
  - REPLACE → we=1, delta=00, wd=req_data
  - POPREPL → we=1, delta=11, wd=req_data (nip-and-write: the head takes wd, the tail shifts down)
  - NOP and reserved codes → we=0, delta=00; stk_wd unchanged
- Depth updates on acceptance, in the same edge as the output register:
  - PUSH: +1; if already CAP, stays CAP and sets err_ovf (bottom cell lost).
  - POP: −1; if 0, stays 0 and sets err_unf.
  - REPLACE: unchanged if ≥1; if 0, becomes 1 and sets err_unf.
  - POPREPL: −1 if ≥2; if <2, becomes 1 and sets err_unf.
- Sticky flags: when err_clr coincides with a new set event, set wins. err_clr acts regardless of hold.
- empty and full are combinational from depth.

Optional Feature:
- Macro: STACK_CTL_GUARD_EN.
- Defined: ops that would overflow or underflow are still accepted and flagged, but are issued to the stack as NOP, and depth is unchanged.
  - REPLACE at depth 0 is also suppressed.
  - This preserves stack contents on error.
- Undefined: ops are issued exactly as encoded, with the saturation rules above.

Decomposition:
- Shared package stack_pkg:
  - op-code localparams (OP_NOP, OP_PUSH, OP_POP, OP_REPLACE, OP_POPREPL)
  - delta encodings (DELTA_NONE=00, DELTA_PUSH=01, DELTA_POP=11)
  - the EMPTY fill pattern shared with the stack
- One natural sub-module, stack_depth: the saturating occupancy counter plus over/underflow detection. Inputs: op and accept strobe. Outputs: depth and error pulses.

Test Plan:
- Reset, then PUSH 0x00011, 0x00022, POP → stk_* = (1,01,0x11), (1,01,0x22), (0,11) on successive cycles; depth 1,2,1.
- 17 PUSHes (DEPTH=16) then one more → depth saturates at 17, full=1, err_ovf=1 on the 18th; err_clr → err_ovf=0.
- POP at depth 0 → err_unf=1, depth=0, stk_delta=11 (guard off) or 00 (guard on).
- PUSH issued with hold=1 for 3 cycles → req_ready=0, stk_* and depth frozen; accepted on the first hold=0 cycle.
- Depth 3, POPREPL 0x3FFFF → stk_we=1, stk_delta=11, stk_wd=0x3FFFF, depth=2; at depth 1 → err_unf, depth=1.
- Assert rst_n low the cycle after accepting PUSH → outputs return to NOP immediately, depth=0, no update issued.
